// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup and decode resolution signals of the branch predictor
interface branch_predictor_if;
  logic [15:0] PC_curr;
  logic        update_en;
  logic [15:0] update_PC;
  logic        actual_taken;
  logic [15:0] actual_target;
  logic        update_pred_taken;
  logic [15:0] update_pred_target;
  logic        predicted_taken;
  logic [15:0] predicted_target;
  logic        hit;
  logic        mispredict;
  logic [15:0] mispredict_count;
  modport master (
    output PC_curr, update_en, update_PC, actual_taken, actual_target,
           update_pred_taken, update_pred_target,
    input  predicted_taken, predicted_target, hit, mispredict, mispredict_count
  );
  modport slave (
    input  PC_curr, update_en, update_PC, actual_taken, actual_target,
           update_pred_taken, update_pred_target,
    output predicted_taken, predicted_target, hit, mispredict, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: 8-entry direct-mapped BTB with 2-bit saturating counters and mispredict counter
module branch_predictor (
  input logic clk,
  input logic rst,
  branch_predictor_if.slave bp
);
  logic        valid [8];
  logic [11:0] tag   [8];
  logic [1:0]  cnt   [8];
  logic [15:0] tgt   [8];
  logic [15:0] count;
  logic [2:0]  li, ui;
  logic        uhit;
  assign li = bp.PC_curr[3:1];
  assign ui = bp.update_PC[3:1];
  assign bp.hit = valid[li] && (tag[li] == bp.PC_curr[15:4]);
  assign bp.predicted_taken = bp.hit && cnt[li][1];
  assign bp.predicted_target = bp.hit ? tgt[li] : 16'h0000;
  assign uhit = valid[ui] && (tag[ui] == bp.update_PC[15:4]);
  assign bp.mispredict = bp.update_en && ((bp.update_pred_taken != bp.actual_taken) ||
                         (bp.actual_taken && bp.update_pred_target != bp.actual_target));
  assign bp.mispredict_count = count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        valid[i] <= 1'b0;
        tag[i]   <= '0;
        cnt[i]   <= 2'b01;
        tgt[i]   <= '0;
      end
      count <= '0;
    end else begin
      if (bp.update_en && uhit) begin
        cnt[ui] <= bp.actual_taken ? ((cnt[ui] == 2'b11) ? 2'b11 : cnt[ui] + 2'd1)
                                   : ((cnt[ui] == 2'b00) ? 2'b00 : cnt[ui] - 2'd1);
        if (bp.actual_taken) tgt[ui] <= bp.actual_target;
      end else if (bp.update_en && bp.actual_taken) begin
        valid[ui] <= 1'b1;
        tag[ui]   <= bp.update_PC[15:4];
        cnt[ui]   <= 2'b10;
        tgt[ui]   <= bp.actual_target;
      end
      if (bp.mispredict && count != 16'hFFFF) count <= count + 16'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: randomized and directed checks of branch_predictor against a table model
module tb_branch_predictor;
  logic clk = 0;
  logic rst = 1;
  int checks = 0, failures = 0;
  bit quiet = 0;
  branch_predictor_if bp ();
  branch_predictor dut (.clk(clk), .rst(rst), .bp(bp));
  always #5 clk = ~clk;

  bit m_v   [8];
  int m_tag [8];
  int m_cnt [8];
  int m_tgt [8];
  int m_count;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic int slot(input int pc);
    return (pc / 2) % 8;
  endfunction
  function automatic bit m_hit(input int pc);
    return m_v[slot(pc)] && m_tag[slot(pc)] == pc / 16;
  endfunction
  function automatic bit m_pt(input int pc);
    return m_hit(pc) && m_cnt[slot(pc)] >= 2;
  endfunction
  function automatic int m_ptgt(input int pc);
    return m_hit(pc) ? m_tgt[slot(pc)] : 0;
  endfunction
  function automatic bit m_misp();
    return bp.update_en && (bp.update_pred_taken != bp.actual_taken ||
           (bp.actual_taken && bp.update_pred_target != bp.actual_target));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_cnt[i] = 1; m_tgt[i] = 0;
    end
    m_count = 0;
  endtask

  task automatic m_update();
    int pc, s;
    pc = int'(bp.update_PC);
    s = slot(pc);
    if (m_misp() && m_count < 65535) m_count++;
    if (!bp.update_en) return;
    if (m_hit(pc)) begin
      if (bp.actual_taken) begin
        m_cnt[s] = (m_cnt[s] < 3) ? m_cnt[s] + 1 : 3;
        m_tgt[s] = int'(bp.actual_target);
      end else m_cnt[s] = (m_cnt[s] > 0) ? m_cnt[s] - 1 : 0;
    end else if (bp.actual_taken) begin
      m_v[s] = 1; m_tag[s] = pc / 16; m_cnt[s] = 2; m_tgt[s] = int'(bp.actual_target);
    end
  endtask

  task automatic set_upd(input logic en, input logic [15:0] upc, input logic tk,
                         input logic [15:0] tg, input logic pt, input logic [15:0] ptg);
    bp.update_en = en; bp.update_PC = upc; bp.actual_taken = tk;
    bp.actual_target = tg; bp.update_pred_taken = pt; bp.update_pred_target = ptg;
  endtask

  task automatic cycle();
    int pc;
    #1;
    pc = int'(bp.PC_curr);
    if (!quiet) begin
      check("hit", bp.hit, m_hit(pc));
      check("pred_taken", bp.predicted_taken, m_pt(pc));
      check("pred_target", bp.predicted_target, m_ptgt(pc));
      check("mispredict", bp.mispredict, m_misp());
      check("count", bp.mispredict_count, m_count);
    end
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  initial begin
    logic [11:0] tags [3];
    logic [15:0] pc;
    tags[0] = 12'h002; tags[1] = 12'h012; tags[2] = 12'hA5C;
    m_reset();
    bp.PC_curr = 16'h0010;
    set_upd(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("rst_hit", bp.hit, 0);
    check("rst_pt", bp.predicted_taken, 0);
    check("rst_ptgt", bp.predicted_target, 0);
    check("rst_count", bp.mispredict_count, 0);
    rst = 0;
    @(negedge clk);
    cycle();
    // allocate 0x0024 with a mispredict
    set_upd(1, 16'h0024, 1, 16'h0100, 0, 16'h0000);
    bp.PC_curr = 16'h0024;
    #1 check("alloc_misp", bp.mispredict, 1);
    cycle();
    set_upd(0, 0, 0, 0, 0, 0);
    #1 check("alloc_hit", bp.hit, 1);
    check("alloc_ptgt", bp.predicted_target, 16'h0100);
    check("alloc_count", bp.mispredict_count, 1);
    cycle();
    set_upd(1, 16'h0024, 0, 0, 1, 16'h0100);
    cycle();
    #1 check("nt1_pt", bp.predicted_taken, 0);
    check("nt1_hit", bp.hit, 1);
    cycle(); cycle();
    set_upd(1, 16'h0024, 1, 16'h0100, 0, 16'h0100);
    cycle();
    set_upd(0, 0, 0, 0, 0, 0);
    #1 check("t_after_nt_pt", bp.predicted_taken, 0);
    cycle();
    // aliasing at idx 2
    set_upd(1, 16'h0124, 1, 16'h0200, 0, 0);
    cycle();
    set_upd(0, 0, 0, 0, 0, 0);
    #1 check("alias_old_hit", bp.hit, 0);
    cycle();
    bp.PC_curr = 16'h0124;
    #1 check("alias_ptgt", bp.predicted_target, 16'h0200);
    check("alias_pt", bp.predicted_taken, 1);
    set_upd(1, 16'h0124, 0, 0, 1, 16'h0200);
    #1 check("same_cycle_pt_old", bp.predicted_taken, 1);
    cycle();
    set_upd(0, 16'h0124, 1, 16'h0300, 0, 16'h0000);
    #1 check("same_cycle_pt_new", bp.predicted_taken, 0);
    check("noen_misp", bp.mispredict, 0);
    cycle();
    #1 check("noen_ptgt", bp.predicted_target, 16'h0200);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      pc = {tags[$urandom_range(0, 2)], 3'($urandom_range(0, 7)), 1'($urandom)};
      bp.PC_curr = {tags[$urandom_range(0, 2)], 3'($urandom_range(0, 7)), 1'($urandom)};
      set_upd($urandom_range(0, 4) != 0, pc, 1'($urandom),
              16'($urandom_range(0, 3) * 16'h40),
              ($urandom_range(0, 2) != 0) ? m_pt(int'(pc)) : 1'($urandom),
              ($urandom_range(0, 2) != 0) ? 16'(m_ptgt(int'(pc))) : 16'($urandom_range(0, 3) * 16'h40));
      cycle();
    end
    // reset wins over a simultaneous update
    set_upd(1, 16'h0E0A, 1, 16'h1234, 0, 0);
    bp.PC_curr = 16'h0E0A;
    rst = 1;
    @(posedge clk);
    m_reset();
    @(negedge clk);
    rst = 0;
    set_upd(0, 0, 0, 0, 0, 0);
    #1 check("rst_vs_upd_hit", bp.hit, 0);
    cycle();
    // saturate the mispredict counter
    quiet = 1;
    set_upd(1, 16'h0024, 1, 16'h0100, 0, 0);
    cycle();
    set_upd(1, 16'h0064, 0, 0, 1, 0);
    for (int n = 0; n < 65540; n++) cycle();
    quiet = 0;
    check("sat_count", bp.mispredict_count, 16'hFFFF);
    cycle();
    bp.PC_curr = 16'h0024;
    #1 check("sat_hold", bp.mispredict_count, 16'hFFFF);
    check("pre_async_hit", bp.hit, 1);
    #2 rst = 1;
    #1 check("async_count", bp.mispredict_count, 0);
    check("async_hit", bp.hit, 0);
    check("async_ptgt", bp.predicted_target, 0);
    m_reset();
    @(negedge clk);
    rst = 0;
    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
